instr_exec: RTL and testbench
=============================

INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 base_addr  input  12  address of the instruction currently presented by instr_decode.
REQ-005 pdp_mem_opcode  input  pdp_mem_opcode_s  one-hot flags NOP, AND, TAD, ISZ, DCA, JMS, JMP, plus 12-bit mem_inst_addr (effective address).
REQ-006 pdp_op7_opcode  input  pdp_op7_opcode_s  one-hot flags NOP, CLA, CLL, CMA, CML, IAC, RAR, RAL, HLT, SZA, SNA, SMA, SPA, SNL, SZL.
REQ-007 stall  output  1  high = execute busy; decode holds its outputs.
REQ-008 PC_value  output  12  next fetch address for decode.
REQ-009 exec_rd_req / exec_rd_addr  output  1 / 12  memory read request and address.
REQ-010 exec_rd_data  input  12  read data, valid the cycle after exec_rd_req.
REQ-011 exec_wr_req / exec_wr_addr / exec_wr_data  output  1 / 12 / 12  single-cycle memory write.
REQ-012 ac_value / link_value  output  12 / 1  accumulator and link, exported for checkers.

Function
REQ-013 States SHALL be IDLE, EXEC, RD, DATA, WR, HALT; stall = (state != IDLE), combinational.
REQ-014 An instruction SHALL be accepted on a clk edge with state IDLE and at least one flag set across both structs; all-zero inputs are bubbles (no state change).
REQ-015 More than one flag set SHALL be executed as NOP.
REQ-016 Opcode, base_addr and mem_inst_addr SHALL be latched at acceptance; input changes while stall=1 SHALL be ignored.
REQ-017 Default next PC = base_addr+1 mod 4096; skip PC = base_addr+2 mod 4096 (wrap 7777->0000, 7776->0000).
REQ-018 NOP, JMP, all op7: IDLE->EXEC->IDLE; AC/L/PC updated at end of EXEC (stall high 1 cycle).
REQ-019 JMP SHALL set PC = mem_inst_addr.
REQ-020 AND/TAD: IDLE->RD (rd_req=1, rd_addr=mem_inst_addr)->DATA->IDLE; AC/L/PC updated at end of DATA (stall 2 cycles).
REQ-021 AND: AC = AC & data. TAD: 13-bit sum = AC+data; AC = sum[11:0]; L = L ^ sum[12].
REQ-022 ISZ: RD->DATA->WR (wr_req=1, wr_data=data+1 mod 4096)->IDLE; PC = skip PC if data+1 wraps to 0, else default (stall 3 cycles).
REQ-023 DCA: IDLE->WR (wr_data=AC)->IDLE; AC=0 at end of WR.
REQ-024 JMS: IDLE->WR (wr_data=base_addr+1)->IDLE; PC = mem_inst_addr+1 mod 4096.
REQ-025 CLA: AC=0. CLL: L=0. CMA: AC=~AC. CML: L=~L. IAC: {L,AC} = {L,AC} + 1 as 13-bit, carry into L bit complements L.
REQ-026 RAR/RAL: rotate 13-bit {L,AC} right/left by one.
REQ-027 Skips (PC = skip PC when true): SZA AC==0; SNA AC!=0; SMA AC[11]==1; SPA AC[11]==0; SNL L==1; SZL L==0.
REQ-028 HLT: EXEC->HALT; PC = base_addr+1; HALT SHALL persist, ignoring inputs, until reset.
REQ-029 exec_rd_req high only in RD, exec_wr_req only in WR, each exactly one cycle per instruction; addresses/data SHALL be 0 when the request is low.

Reset
REQ-030 On reset: state=IDLE, stall=0, PC_value=12'o0200, AC=0, L=0, all req outputs 0, addr/data outputs 0.
REQ-031 Reset in any state, including mid-RD/DATA/WR or HALT, SHALL abort the instruction with no write issued on the following cycle.
REQ-032 Reset SHALL take priority over acceptance in the same cycle.

Verification
REQ-033 Reset, then CLA+IAC at base_addr 0200 -> AC=0001, L=0, PC_value=0202, stall high exactly 1 cycle each.
REQ-034 AC=7777, L=0, TAD to 0300 with mem[0300]=0001 -> rd_req one cycle at 0300, AC=0000, L=1, stall 2 cycles.
REQ-035 ISZ at 0400, mem[0400]=7777, base_addr 0210 -> write 0000 to 0400, PC_value=0212, stall 3 cycles.
REQ-036 JMS to 0500 from base_addr 7777 -> write 0000 to 0500, PC_value=0501; then DCA 0600 with AC=1234 -> write 1234 to 0600, AC=0.
REQ-037 HLT, then TAD inputs for 10 cycles -> stall stays 1, no req; reset -> IDLE, PC_value=0200.
REQ-038 Reset asserted in DATA state of an ISZ -> no exec_wr_req, outputs at reset values next cycle.

Source files
------------

// File: rtl/instr_exec_if.sv
// Opcode structures, FSM state encoding and the decode/memory-facing bus
// of the PDP-8 style execute stage.
package instr_exec_pkg;

  typedef struct packed {
    logic        NOP;
    logic        AND;
    logic        TAD;
    logic        ISZ;
    logic        DCA;
    logic        JMS;
    logic        JMP;
    logic [11:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic CLA;
    logic CLL;
    logic CMA;
    logic CML;
    logic IAC;
    logic RAR;
    logic RAL;
    logic HLT;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic SNL;
    logic SZL;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_RD   = 3'd2,
    S_DATA = 3'd3,
    S_WR   = 3'd4,
    S_HALT = 3'd5
  } state_e;

endpackage

// Handshake: decode presents an instruction by setting at least one opcode
// flag; it is taken on the rising edge where stall is low. While stall is
// high the presented inputs are ignored and decode holds them. Memory reads
// return exec_rd_data the cycle after exec_rd_req; writes complete in the
// single cycle exec_wr_req is high.
interface instr_exec_if;
  import instr_exec_pkg::*;

  logic [11:0]     base_addr;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic            stall;
  logic [11:0]     PC_value;
  logic            exec_rd_req;
  logic [11:0]     exec_rd_addr;
  logic [11:0]     exec_rd_data;
  logic            exec_wr_req;
  logic [11:0]     exec_wr_addr;
  logic [11:0]     exec_wr_data;
  logic [11:0]     ac_value;
  logic            link_value;

  modport master (
    output base_addr, pdp_mem_opcode, pdp_op7_opcode, exec_rd_data,
    input  stall, PC_value, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, ac_value, link_value
  );

  modport slave (
    input  base_addr, pdp_mem_opcode, pdp_op7_opcode, exec_rd_data,
    output stall, PC_value, exec_rd_req, exec_rd_addr,
           exec_wr_req, exec_wr_addr, exec_wr_data, ac_value, link_value
  );

endinterface

// File: rtl/instr_exec.sv
// Execute stage: runs one memory-reference or operate-group instruction at a
// time, owning AC, link and the next fetch address.
module instr_exec
  import instr_exec_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  instr_exec_if.slave  bus,
  output state_e       o_state
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [11:0]     r_pc;
  logic [11:0]     r_ac;
  logic            r_link;
  logic [11:0]     r_base;
  logic [11:0]     r_data;
  pdp_mem_opcode_s r_mem;
  pdp_op7_opcode_s r_op7;

  logic [11:0] w_pc_nxt;
  logic [11:0] w_ac_nxt;
  logic        w_link_nxt;
  logic [21:0] w_flags;
  logic        w_any;
  logic        w_multi;
  logic        w_accept;
  logic [11:0] w_pc_inc;
  logic [11:0] w_pc_skip;
  logic [11:0] w_jms_pc;
  logic [11:0] w_isz_val;
  logic [12:0] w_tad_sum;

  // All opcode flags in one vector; more than one set means NOP.
  assign w_flags  = {bus.pdp_mem_opcode.NOP, bus.pdp_mem_opcode.AND,
                     bus.pdp_mem_opcode.TAD, bus.pdp_mem_opcode.ISZ,
                     bus.pdp_mem_opcode.DCA, bus.pdp_mem_opcode.JMS,
                     bus.pdp_mem_opcode.JMP, bus.pdp_op7_opcode};
  assign w_any    = |w_flags;
  assign w_multi  = |(w_flags & (w_flags - 22'd1));
  assign w_accept = (r_state == S_IDLE) && w_any;

  assign w_pc_inc  = r_base + 12'd1;
  assign w_pc_skip = r_base + 12'd2;
  assign w_jms_pc  = r_mem.mem_inst_addr + 12'd1;
  assign w_isz_val = r_data + 12'd1;
  assign w_tad_sum = {1'b0, r_ac} + {1'b0, bus.exec_rd_data};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and next architectural values (AC, link, PC).
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ac_nxt    = r_ac;
    w_link_nxt  = r_link;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_multi)
            w_state_nxt = S_EXEC;
          else if (bus.pdp_mem_opcode.AND || bus.pdp_mem_opcode.TAD ||
                   bus.pdp_mem_opcode.ISZ)
            w_state_nxt = S_RD;
          else if (bus.pdp_mem_opcode.DCA || bus.pdp_mem_opcode.JMS)
            w_state_nxt = S_WR;
          else
            w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = w_pc_inc;
        if (r_mem.NOP || r_op7.NOP) begin
          w_pc_nxt = w_pc_inc;
        end
        else if (r_mem.JMP) w_pc_nxt = r_mem.mem_inst_addr;
        else if (r_op7.CLA) w_ac_nxt = 12'd0;
        else if (r_op7.CLL) w_link_nxt = 1'b0;
        else if (r_op7.CMA) w_ac_nxt = ~r_ac;
        else if (r_op7.CML) w_link_nxt = ~r_link;
        else if (r_op7.IAC) {w_link_nxt, w_ac_nxt} = {r_link, r_ac} + 13'd1;
        else if (r_op7.RAR) {w_link_nxt, w_ac_nxt} = {r_ac[0], r_link, r_ac[11:1]};
        else if (r_op7.RAL) {w_link_nxt, w_ac_nxt} = {r_ac, r_link};
        else if (r_op7.HLT) w_state_nxt = S_HALT;
        else if (r_op7.SZA) begin if (r_ac == 12'd0) w_pc_nxt = w_pc_skip; end
        else if (r_op7.SNA) begin if (r_ac != 12'd0) w_pc_nxt = w_pc_skip; end
        else if (r_op7.SMA) begin if (r_ac[11])      w_pc_nxt = w_pc_skip; end
        else if (r_op7.SPA) begin if (!r_ac[11])     w_pc_nxt = w_pc_skip; end
        else if (r_op7.SNL) begin if (r_link)        w_pc_nxt = w_pc_skip; end
        else if (r_op7.SZL) begin if (!r_link)       w_pc_nxt = w_pc_skip; end
      end
      S_RD: w_state_nxt = S_DATA;
      S_DATA: begin
        if (r_mem.AND) begin
          w_state_nxt = S_IDLE;
          w_ac_nxt    = r_ac & bus.exec_rd_data;
          w_pc_nxt    = w_pc_inc;
        end
        else if (r_mem.TAD) begin
          w_state_nxt = S_IDLE;
          w_ac_nxt    = w_tad_sum[11:0];
          w_link_nxt  = r_link ^ w_tad_sum[12];
          w_pc_nxt    = w_pc_inc;
        end
        else begin
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = w_pc_inc;
        if (r_mem.DCA)                w_ac_nxt = 12'd0;
        else if (r_mem.JMS)           w_pc_nxt = w_jms_pc;
        else if (w_isz_val == 12'd0)  w_pc_nxt = w_pc_skip;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Architectural registers and the instruction latched at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= 12'o0200;
      r_ac   <= 12'd0;
      r_link <= 1'b0;
      r_base <= 12'd0;
      r_data <= 12'd0;
      r_mem  <= '0;
      r_op7  <= '0;
    end
    else begin
      r_pc   <= w_pc_nxt;
      r_ac   <= w_ac_nxt;
      r_link <= w_link_nxt;
      if (w_accept) begin
        r_base <= bus.base_addr;
        // A multi-flag instruction is stored as all-zero and runs as NOP.
        r_mem  <= w_multi ? '0 : bus.pdp_mem_opcode;
        r_op7  <= w_multi ? '0 : bus.pdp_op7_opcode;
      end
      if (r_state == S_DATA) r_data <= bus.exec_rd_data;
    end
  end

  // Bus outputs are decoded from state; address/data are zero when idle.
  always_comb begin
    bus.stall        = (r_state != S_IDLE);
    bus.PC_value     = r_pc;
    bus.ac_value     = r_ac;
    bus.link_value   = r_link;
    bus.exec_rd_req  = (r_state == S_RD);
    bus.exec_rd_addr = 12'd0;
    bus.exec_wr_req  = (r_state == S_WR);
    bus.exec_wr_addr = 12'd0;
    bus.exec_wr_data = 12'd0;
    if (r_state == S_RD) bus.exec_rd_addr = r_mem.mem_inst_addr;
    if (r_state == S_WR) begin
      bus.exec_wr_addr = r_mem.mem_inst_addr;
      if (r_mem.DCA)      bus.exec_wr_data = r_ac;
      else if (r_mem.JMS) bus.exec_wr_data = w_pc_inc;
      else                bus.exec_wr_data = w_isz_val;
    end
    o_state = r_state;
  end

endmodule

// File: tb/tb_instr_exec.sv
// Directed bench for instr_exec with a memory responder and read/write
// scoreboards.
module tb_instr_exec;
  import instr_exec_pkg::*;

  localparam logic [6:0]  M_AND = 7'b0100000;
  localparam logic [6:0]  M_TAD = 7'b0010000;
  localparam logic [6:0]  M_ISZ = 7'b0001000;
  localparam logic [6:0]  M_DCA = 7'b0000100;
  localparam logic [6:0]  M_JMS = 7'b0000010;
  localparam logic [6:0]  M_JMP = 7'b0000001;
  localparam logic [14:0] O_CLA = 15'h1 << 13;
  localparam logic [14:0] O_CLL = 15'h1 << 12;
  localparam logic [14:0] O_CMA = 15'h1 << 11;
  localparam logic [14:0] O_CML = 15'h1 << 10;
  localparam logic [14:0] O_IAC = 15'h1 << 9;
  localparam logic [14:0] O_RAR = 15'h1 << 8;
  localparam logic [14:0] O_RAL = 15'h1 << 7;
  localparam logic [14:0] O_HLT = 15'h1 << 6;
  localparam logic [14:0] O_SZA = 15'h1 << 5;
  localparam logic [14:0] O_SNA = 15'h1 << 4;
  localparam logic [14:0] O_SMA = 15'h1 << 3;
  localparam logic [14:0] O_SPA = 15'h1 << 2;
  localparam logic [14:0] O_SNL = 15'h1 << 1;
  localparam logic [14:0] O_SZL = 15'h1;

  logic        clk;
  logic        reset;
  state_e      state;
  instr_exec_if bus();

  logic [11:0] mem [0:4095];
  logic [23:0] exp_q[$];
  logic [11:0] rd_q[$];
  int          n_cmp;
  int          n_err;
  int          n_st;

  instr_exec u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // memory responder: read data valid the cycle after the request
  always @(posedge clk)
    bus.exec_rd_data <= bus.exec_rd_req ? mem[bus.exec_rd_addr] : 12'd0;

  // read/write monitors popping the scoreboard queues
  always @(negedge clk) begin
    if (bus.exec_rd_req) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", bus.exec_rd_addr, rd_q.pop_front());
    end
    else if (bus.exec_rd_addr !== 12'd0) check("rd_addr_idle", bus.exec_rd_addr, 0);
    if (bus.exec_wr_req) begin
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_addr_data", {bus.exec_wr_addr, bus.exec_wr_data}, exp_q.pop_front());
    end
    else if ({bus.exec_wr_addr, bus.exec_wr_data} !== 24'd0)
      check("wr_bus_idle", {bus.exec_wr_addr, bus.exec_wr_data}, 0);
  end

  // driver tasks
  task automatic clear_inputs();
    bus.base_addr      = 12'd0;
    bus.pdp_mem_opcode = '0;
    bus.pdp_op7_opcode = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input logic [11:0] base, input logic [6:0] mf,
                       input logic [11:0] ea, input logic [14:0] of);
    bus.base_addr      = base;
    bus.pdp_mem_opcode = {mf, ea};
    bus.pdp_op7_opcode = of;
    @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic settle(output int n);
    n = 0;
    while (bus.stall && n < 8) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op(input string tag, input logic [11:0] base, input logic [6:0] mf,
                    input logic [11:0] ea, input logic [14:0] of, input int exp_st,
                    input logic [11:0] e_ac, input logic e_l, input logic [11:0] e_pc);
    drive(base, mf, ea, of);
    settle(n_st);
    check($sformatf("%s_stall", tag), n_st, exp_st);
    check($sformatf("%s_ac", tag), bus.ac_value, e_ac);
    check($sformatf("%s_link", tag), bus.link_value, e_l);
    check($sformatf("%s_pc", tag), bus.PC_value, e_pc);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_stall"}, bus.stall, 0);
    check({tag, "_pc"}, bus.PC_value, 12'o0200);
    check({tag, "_ac"}, bus.ac_value, 0);
    check({tag, "_link"}, bus.link_value, 0);
    check({tag, "_req"}, {bus.exec_rd_req, bus.exec_wr_req}, 0);
  endtask

  // directed sequence
  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom_range(0, 4095));
    mem[12'o0300] = 12'o0001;
    mem[12'o0400] = 12'o7777;
    mem[12'o0410] = 12'o0005;
    mem[12'o0700] = 12'o1234;
    mem[12'o0710] = 12'o0707;
    do_reset();
    check_reset_vals("reset");

    op("cla", 12'o0200, 0, 0, O_CLA, 1, 12'o0000, 0, 12'o0201);
    op("iac", 12'o0201, 0, 0, O_IAC, 1, 12'o0001, 0, 12'o0202);
    op("cla2", 12'o0202, 0, 0, O_CLA, 1, 12'o0000, 0, 12'o0203);
    op("cma", 12'o0203, 0, 0, O_CMA, 1, 12'o7777, 0, 12'o0204);
    rd_q.push_back(12'o0300);
    op("tad_carry", 12'o0204, M_TAD, 12'o0300, 0, 2, 12'o0000, 1, 12'o0205);
    rd_q.push_back(12'o0400);
    exp_q.push_back({12'o0400, 12'o0000});
    op("isz_skip", 12'o0210, M_ISZ, 12'o0400, 0, 3, 12'o0000, 1, 12'o0212);

    op("sza", 12'o0220, 0, 0, O_SZA, 1, 12'o0000, 1, 12'o0222);
    op("sna", 12'o0230, 0, 0, O_SNA, 1, 12'o0000, 1, 12'o0231);
    op("snl", 12'o0240, 0, 0, O_SNL, 1, 12'o0000, 1, 12'o0242);
    op("szl", 12'o0250, 0, 0, O_SZL, 1, 12'o0000, 1, 12'o0251);
    op("ral", 12'o0260, 0, 0, O_RAL, 1, 12'o0001, 0, 12'o0261);
    op("rar", 12'o0261, 0, 0, O_RAR, 1, 12'o0000, 1, 12'o0262);
    op("cml", 12'o0262, 0, 0, O_CML, 1, 12'o0000, 0, 12'o0263);
    op("sza_wrap", 12'o7776, 0, 0, O_SZA, 1, 12'o0000, 0, 12'o0000);
    op("sna_wrap", 12'o7777, 0, 0, O_SNA, 1, 12'o0000, 0, 12'o0000);
    op("iac2", 12'o0264, 0, 0, O_IAC, 1, 12'o0001, 0, 12'o0265);
    op("multi_nop", 12'o0270, M_TAD, 12'o0300, O_CLA | O_IAC, 1, 12'o0001, 0, 12'o0271);
    op("sma_no", 12'o0272, 0, 0, O_SMA, 1, 12'o0001, 0, 12'o0273);
    op("spa_yes", 12'o0274, 0, 0, O_SPA, 1, 12'o0001, 0, 12'o0276);
    op("cma2", 12'o0276, 0, 0, O_CMA, 1, 12'o7776, 0, 12'o0277);
    op("sma_yes", 12'o0300, 0, 0, O_SMA, 1, 12'o7776, 0, 12'o0302);
    op("spa_no", 12'o0302, 0, 0, O_SPA, 1, 12'o7776, 0, 12'o0303);
    op("cml2", 12'o0303, 0, 0, O_CML, 1, 12'o7776, 1, 12'o0304);
    op("cll", 12'o0304, 0, 0, O_CLL, 1, 12'o7776, 0, 12'o0305);
    op("iac3", 12'o0305, 0, 0, O_IAC, 1, 12'o7777, 0, 12'o0306);
    op("iac_carry", 12'o0306, 0, 0, O_IAC, 1, 12'o0000, 1, 12'o0307);
    op("cma3", 12'o0307, 0, 0, O_CMA, 1, 12'o7777, 1, 12'o0310);
    rd_q.push_back(12'o0710);
    op("and", 12'o0310, M_AND, 12'o0710, 0, 2, 12'o0707, 1, 12'o0311);
    op("jmp", 12'o0100, M_JMP, 12'o0123, 0, 1, 12'o0707, 1, 12'o0123);
    exp_q.push_back({12'o0500, 12'o0000});
    op("jms", 12'o7777, M_JMS, 12'o0500, 0, 1, 12'o0707, 1, 12'o0501);
    op("cla3", 12'o0501, 0, 0, O_CLA, 1, 12'o0000, 1, 12'o0502);
    rd_q.push_back(12'o0700);
    op("tad", 12'o0502, M_TAD, 12'o0700, 0, 2, 12'o1234, 1, 12'o0503);
    exp_q.push_back({12'o0600, 12'o1234});
    op("dca", 12'o0503, M_DCA, 12'o0600, 0, 1, 12'o0000, 1, 12'o0504);

    // reset wins over a same-cycle acceptance
    bus.pdp_op7_opcode = O_IAC;
    bus.base_addr = 12'o0504;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_inputs();
    check_reset_vals("rst_prio");

    // halt holds against presented instructions until reset
    drive(12'o0300, 0, 0, O_HLT);
    @(posedge clk);
    #1;
    check("hlt_state", state, S_HALT);
    check("hlt_pc", bus.PC_value, 12'o0301);
    bus.base_addr = 12'o0301;
    bus.pdp_mem_opcode = {M_TAD, 12'o0300};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check($sformatf("hlt_stall_%0d", i), bus.stall, 1);
    end
    do_reset();
    check_reset_vals("hlt_reset");

    // reset while an ISZ sits in DATA: no write afterwards
    rd_q.push_back(12'o0410);
    drive(12'o0400, M_ISZ, 12'o0410, 0);
    check("isz_rd_state", state, S_RD);
    @(posedge clk);
    #1 check("isz_data_state", state, S_DATA);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals("isz_abort");
    repeat (3) @(posedge clk);
    #1 check("isz_abort_idle", state, S_IDLE);

    check("wr_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
